// File: rtl/cpu_pkg.sv
// Size constants and fetch FSM state type shared by the fetch and decode stages.
package cpu_pkg;

  localparam int unsigned INSTRUCTION_SIZE     = 20;
  localparam int unsigned PC_SIZE              = 16;
  localparam int unsigned SMALL_IMMEDIATE_SIZE = 10;
  localparam int unsigned JUMP_ADDRESS_SIZE    = 9;

  // FETCH: request outstanding or about to issue; DROP: stale request draining;
  // HOLD: buffered word offered to decode.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DROP  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/instruction_fetch_if.sv
// Instruction memory, decode handshake and redirect signals of the fetch stage.
interface instruction_fetch_if #(
  parameter int unsigned INSTRUCTION_SIZE     = cpu_pkg::INSTRUCTION_SIZE,
  parameter int unsigned PC_SIZE              = cpu_pkg::PC_SIZE,
  parameter int unsigned SMALL_IMMEDIATE_SIZE = cpu_pkg::SMALL_IMMEDIATE_SIZE,
  parameter int unsigned JUMP_ADDRESS_SIZE    = cpu_pkg::JUMP_ADDRESS_SIZE
);

  logic                            imem_req;
  logic [PC_SIZE-1:0]              imem_addr;
  logic                            imem_ack;
  logic [INSTRUCTION_SIZE-1:0]     imem_rdata;

  logic                            instr_valid;
  logic                            instr_ready;
  logic [INSTRUCTION_SIZE-1:0]     instruction;
  logic [PC_SIZE-1:0]              instr_pc;

  logic                            redirect_valid;
  logic                            redirect_jump;
  logic [PC_SIZE-1:0]              redirect_pc;
  logic [SMALL_IMMEDIATE_SIZE-1:0] redirect_offset;
  logic [JUMP_ADDRESS_SIZE-1:0]    redirect_jaddr;

  // Fetch unit side
  modport master (
    output imem_req, imem_addr, instr_valid, instruction, instr_pc,
    input  imem_ack, imem_rdata, instr_ready,
    input  redirect_valid, redirect_jump, redirect_pc, redirect_offset, redirect_jaddr
  );

  // Memory, decode and branch-resolution side
  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, instr_pc,
    output imem_ack, imem_rdata, instr_ready,
    output redirect_valid, redirect_jump, redirect_pc, redirect_offset, redirect_jaddr
  );

endinterface : instruction_fetch_if

// File: rtl/next_pc_calc.sv
// Combinational redirect target (branch or jump) and sequential PC increment.
module next_pc_calc #(
  parameter int unsigned PC_SIZE              = cpu_pkg::PC_SIZE,
  parameter int unsigned SMALL_IMMEDIATE_SIZE = cpu_pkg::SMALL_IMMEDIATE_SIZE,
  parameter int unsigned JUMP_ADDRESS_SIZE    = cpu_pkg::JUMP_ADDRESS_SIZE
) (
  input  logic                            i_jump,
  input  logic [PC_SIZE-1:0]              i_redirect_pc,
  input  logic [SMALL_IMMEDIATE_SIZE-1:0] i_offset,
  input  logic [JUMP_ADDRESS_SIZE-1:0]    i_jaddr,
  input  logic [PC_SIZE-1:0]              i_pc,
  output logic [PC_SIZE-1:0]              o_target_c,
  output logic [PC_SIZE-1:0]              o_pc_inc_c
);

  localparam int unsigned EXT_W = PC_SIZE - SMALL_IMMEDIATE_SIZE - 2;

  logic [PC_SIZE-1:0] w_branch_off;
  logic [PC_SIZE-1:0] w_branch_tgt;
  logic [PC_SIZE-1:0] w_jump_tgt;

  // Word offset scaled to bytes and sign-extended; sums wrap modulo 2^PC_SIZE.
  assign w_branch_off = {{EXT_W{i_offset[SMALL_IMMEDIATE_SIZE-1]}}, i_offset, 2'b00};
  assign w_branch_tgt = i_redirect_pc + w_branch_off;
  assign w_jump_tgt   = {i_redirect_pc[PC_SIZE-1:JUMP_ADDRESS_SIZE+2], i_jaddr, 2'b00};

  assign o_target_c = i_jump ? w_jump_tgt : w_branch_tgt;
  assign o_pc_inc_c = i_pc + PC_SIZE'(4);

endmodule : next_pc_calc

// File: rtl/instruction_fetch.sv
// Single-outstanding-request instruction fetch stage with a one-word decode buffer.
module instruction_fetch #(
  parameter int unsigned INSTRUCTION_SIZE     = cpu_pkg::INSTRUCTION_SIZE,
  parameter int unsigned PC_SIZE              = cpu_pkg::PC_SIZE,
  parameter int unsigned SMALL_IMMEDIATE_SIZE = cpu_pkg::SMALL_IMMEDIATE_SIZE,
  parameter int unsigned JUMP_ADDRESS_SIZE    = cpu_pkg::JUMP_ADDRESS_SIZE,
  parameter logic [PC_SIZE-1:0] RESET_PC      = '0
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);

  import cpu_pkg::fetch_state_e;
  import cpu_pkg::FETCH;
  import cpu_pkg::DROP;
  import cpu_pkg::HOLD;

  localparam logic [PC_SIZE-1:0] RESET_FETCH_PC = {RESET_PC[PC_SIZE-1:2], 2'b00};

  fetch_state_e                r_state;
  logic [PC_SIZE-1:0]          r_pc;
  logic                        r_req;
  logic [PC_SIZE-1:0]          r_addr;
  logic                        r_valid;
  logic [INSTRUCTION_SIZE-1:0] r_instr;
  logic [PC_SIZE-1:0]          r_ipc;

  fetch_state_e                w_state_nxt;
  logic [PC_SIZE-1:0]          w_pc_nxt;
  logic                        w_req_nxt;
  logic [PC_SIZE-1:0]          w_addr_nxt;
  logic                        w_valid_nxt;
  logic [INSTRUCTION_SIZE-1:0] w_instr_nxt;
  logic [PC_SIZE-1:0]          w_ipc_nxt;

  logic                        w_ack;
  logic [PC_SIZE-1:0]          w_target;
  logic [PC_SIZE-1:0]          w_pc_inc;

  next_pc_calc #(
    .PC_SIZE              (PC_SIZE),
    .SMALL_IMMEDIATE_SIZE (SMALL_IMMEDIATE_SIZE),
    .JUMP_ADDRESS_SIZE    (JUMP_ADDRESS_SIZE)
  ) u_next_pc_calc (
    .i_jump        (bus.redirect_jump),
    .i_redirect_pc (bus.redirect_pc),
    .i_offset      (bus.redirect_offset),
    .i_jaddr       (bus.redirect_jaddr),
    .i_pc          (r_pc),
    .o_target_c    (w_target),
    .o_pc_inc_c    (w_pc_inc)
  );

  // An ack only completes a request that is actually on the bus.
  assign w_ack = bus.imem_ack & r_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_FETCH_PC;
      r_req   <= 1'b0;
      r_addr  <= '0;
      r_valid <= 1'b0;
      r_instr <= '0;
      r_ipc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_valid <= w_valid_nxt;
      r_instr <= w_instr_nxt;
      r_ipc   <= w_ipc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_valid_nxt = r_valid;
    w_instr_nxt = r_instr;
    w_ipc_nxt   = r_ipc;

    unique case (r_state)
      FETCH: begin
        if (bus.redirect_valid) begin
          w_pc_nxt = w_target;
          // Idle bus or ack this cycle: issue the target now; else drain the old request.
          if (w_ack || !r_req) begin
            w_req_nxt  = 1'b1;
            w_addr_nxt = w_target;
          end else begin
            w_state_nxt = DROP;
          end
        end else if (!r_req) begin
          w_req_nxt  = 1'b1;
          w_addr_nxt = r_pc;
        end else if (w_ack) begin
          w_instr_nxt = bus.imem_rdata;
          w_ipc_nxt   = r_pc;
          w_pc_nxt    = w_pc_inc;
          w_req_nxt   = 1'b0;
          w_valid_nxt = 1'b1;
          w_state_nxt = HOLD;
        end
      end

      DROP: begin
        if (bus.redirect_valid) begin
          w_pc_nxt = w_target;
        end
        if (w_ack) begin
          w_state_nxt = FETCH;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = bus.redirect_valid ? w_target : r_pc;
        end
      end

      HOLD: begin
        if (bus.redirect_valid) begin
          w_pc_nxt    = w_target;
          w_valid_nxt = 1'b0;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = w_target;
          w_state_nxt = FETCH;
        end else if (bus.instr_ready) begin
          w_valid_nxt = 1'b0;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_pc;
          w_state_nxt = FETCH;
        end
      end

      default: begin
        w_state_nxt = FETCH;
        w_req_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr_valid = r_valid;
  assign bus.instruction = r_instr;
  assign bus.instr_pc    = r_ipc;

endmodule : instruction_fetch

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, stall, redirects, async reset.
module tb_instruction_fetch;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Memory responder: waits (bounded) for a request, acks after 'delay' cycles.
  task automatic serve(input int delay, input logic [19:0] data,
                       output logic ok, output logic [15:0] addr_seen);
    ok = 1'b0;
    addr_seen = 16'hxxxx;
    for (int i = 0; i < 50; i++) begin
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      addr_seen = bus.imem_addr;
      repeat (delay) @(negedge clk);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = data;
      @(negedge clk);
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got=%0b exp=0", bus.imem_req); end
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%0b exp=0", bus.instr_valid); end
    vectors++; if (bus.instruction !== 20'h0) begin miscompares++; $display("FAIL reset_instr got=%h exp=0", bus.instruction); end
    vectors++; if (bus.instr_pc !== 16'h0) begin miscompares++; $display("FAIL reset_ipc got=%h exp=0", bus.instr_pc); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req got=%0b exp=1", bus.imem_req); end
    vectors++; if (bus.imem_addr !== 16'h0000) begin miscompares++; $display("FAIL first_addr got=%h exp=0000", bus.imem_addr); end
  endtask

  task automatic test_sequential();
    logic ok;
    logic [15:0] a;
    logic [15:0] exp_a;
    logic [19:0] d;
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_a = 16'(4 * k);
      d = 20'hA0000 + 20'(k);
      serve(2, d, ok, a);
      vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL seq%0d_timeout got=%0b exp=1", k, ok); end
      vectors++; if (a !== exp_a) begin miscompares++; $display("FAIL seq%0d_addr got=%h exp=%h", k, a, exp_a); end
      vectors++; if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL seq%0d_valid got=%0b exp=1", k, bus.instr_valid); end
      vectors++; if (bus.instruction !== d) begin miscompares++; $display("FAIL seq%0d_instr got=%h exp=%h", k, bus.instruction, d); end
      vectors++; if (bus.instr_pc !== exp_a) begin miscompares++; $display("FAIL seq%0d_ipc got=%h exp=%h", k, bus.instr_pc, exp_a); end
    end
    @(negedge clk);
  endtask

  task automatic test_hold_stall();
    logic ok;
    logic [15:0] a;
    bus.instr_ready = 1'b0;
    serve(2, 20'h5A5A5, ok, a);
    vectors++; if (a !== 16'h000C) begin miscompares++; $display("FAIL hold_addr got=%h exp=000c", a); end
    for (int c = 0; c < 5; c++) begin
      vectors++; if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL hold%0d_valid got=%0b exp=1", c, bus.instr_valid); end
      vectors++; if (bus.instruction !== 20'h5A5A5) begin miscompares++; $display("FAIL hold%0d_instr got=%h exp=5a5a5", c, bus.instruction); end
      vectors++; if (bus.instr_pc !== 16'h000C) begin miscompares++; $display("FAIL hold%0d_ipc got=%h exp=000c", c, bus.instr_pc); end
      vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL hold%0d_req got=%0b exp=0", c, bus.imem_req); end
      @(negedge clk);
    end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    vectors++; if (bus.imem_addr !== 16'h0010) begin miscompares++; $display("FAIL hold_next_addr got=%h exp=0010", bus.imem_addr); end
  endtask

  task automatic test_branch();
    logic ok;
    logic [15:0] a;
    serve(1, 20'h11111, ok, a);
    vectors++; if (a !== 16'h0010) begin miscompares++; $display("FAIL br_pre_addr got=%h exp=0010", a); end
    bus.redirect_valid = 1'b1; bus.redirect_jump = 1'b0;
    bus.redirect_pc = 16'h0010; bus.redirect_offset = 10'h3FF;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL br_back_valid got=%0b exp=0", bus.instr_valid); end
    vectors++; if (bus.imem_addr !== 16'h000C) begin miscompares++; $display("FAIL br_back_addr got=%h exp=000c", bus.imem_addr); end
    serve(1, 20'h22222, ok, a);
    vectors++; if (bus.instr_pc !== 16'h000C) begin miscompares++; $display("FAIL br_back_ipc got=%h exp=000c", bus.instr_pc); end
    bus.redirect_valid = 1'b1; bus.redirect_offset = 10'h004;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.imem_addr !== 16'h0020) begin miscompares++; $display("FAIL br_fwd_addr got=%h exp=0020", bus.imem_addr); end
    vectors++; if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL br_fwd_req got=%0b exp=1", bus.imem_req); end
  endtask

  task automatic test_jump();
    logic ok;
    logic [15:0] a;
    serve(1, 20'h33333, ok, a);
    vectors++; if (a !== 16'h0020) begin miscompares++; $display("FAIL jmp_pre_addr got=%h exp=0020", a); end
    bus.redirect_valid = 1'b1; bus.redirect_jump = 1'b1;
    bus.redirect_pc = 16'hF804; bus.redirect_jaddr = 9'h1FF;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    vectors++; if (bus.imem_addr !== 16'hFFFC) begin miscompares++; $display("FAIL jmp_addr got=%h exp=fffc", bus.imem_addr); end
    serve(2, 20'h44444, ok, a);
    vectors++; if (bus.instr_pc !== 16'hFFFC) begin miscompares++; $display("FAIL jmp_ipc got=%h exp=fffc", bus.instr_pc); end
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    vectors++; if (bus.imem_addr !== 16'h0000) begin miscompares++; $display("FAIL jmp_wrap_addr got=%h exp=0000", bus.imem_addr); end
  endtask

  task automatic test_redirect_pending();
    logic ok;
    logic [15:0] a;
    bus.redirect_valid = 1'b1; bus.redirect_jump = 1'b0;
    bus.redirect_pc = 16'h0000; bus.redirect_offset = 10'h010;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vectors++; if (bus.imem_addr !== 16'h0000) begin miscompares++; $display("FAIL drop%0d_addr got=%h exp=0000", c, bus.imem_addr); end
      vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL drop%0d_valid got=%0b exp=0", c, bus.instr_valid); end
      @(negedge clk);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 20'hDEAD0;
    @(negedge clk);
    bus.imem_ack = 1'b0;
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL drop_ack_valid got=%0b exp=0", bus.instr_valid); end
    vectors++; if (bus.imem_addr !== 16'h0040) begin miscompares++; $display("FAIL drop_new_addr got=%h exp=0040", bus.imem_addr); end
    serve(1, 20'h55555, ok, a);
    vectors++; if (bus.instruction !== 20'h55555) begin miscompares++; $display("FAIL drop_instr got=%h exp=55555", bus.instruction); end
    vectors++; if (bus.instr_pc !== 16'h0040) begin miscompares++; $display("FAIL drop_ipc got=%h exp=0040", bus.instr_pc); end
    // Redirect coinciding with ack: the response must be thrown away.
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b1; bus.redirect_jump = 1'b1;
    bus.redirect_pc = 16'h0044; bus.redirect_jaddr = 9'h020;
    bus.imem_ack = 1'b1; bus.imem_rdata = 20'hBAD00;
    @(negedge clk);
    bus.redirect_valid = 1'b0; bus.imem_ack = 1'b0;
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL racc_valid got=%0b exp=0", bus.instr_valid); end
    vectors++; if (bus.imem_addr !== 16'h0080) begin miscompares++; $display("FAIL racc_addr got=%h exp=0080", bus.imem_addr); end
    @(negedge clk);
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL racc_valid2 got=%0b exp=0", bus.instr_valid); end
  endtask

  task automatic test_async_reset();
    logic ok;
    logic [15:0] a;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL arst_f_req got=%0b exp=0", bus.imem_req); end
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL arst_f_valid got=%0b exp=0", bus.instr_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus.imem_addr !== 16'h0000 || bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL arst_f_restart got=%h/%0b exp=0000/1", bus.imem_addr, bus.imem_req); end
    serve(1, 20'h66666, ok, a);
    vectors++; if (bus.instr_valid !== 1'b1) begin miscompares++; $display("FAIL arst_h_pre got=%0b exp=1", bus.instr_valid); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL arst_h_valid got=%0b exp=0", bus.instr_valid); end
    vectors++; if (bus.instruction !== 20'h0) begin miscompares++; $display("FAIL arst_h_instr got=%h exp=0", bus.instruction); end
    vectors++; if (bus.instr_pc !== 16'h0) begin miscompares++; $display("FAIL arst_h_ipc got=%h exp=0", bus.instr_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (bus.imem_addr !== 16'h0000 || bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL arst_h_restart got=%h/%0b exp=0000/1", bus.imem_addr, bus.imem_req); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_jump = 1'b0;
    bus.redirect_pc = '0;
    bus.redirect_offset = '0;
    bus.redirect_jaddr = '0;
    test_reset();
    test_sequential();
    test_hold_stall();
    test_branch();
    test_jump();
    test_redirect_pending();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_instruction_fetch

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter INSTRUCTION_SIZE, default 20, instruction word width.
REQ-002 SHALL have parameter PC_SIZE, default 16, byte-address width of PC.
REQ-003 SHALL have parameter SMALL_IMMEDIATE_SIZE, default 10, branch offset width in words.
REQ-004 SHALL have parameter JUMP_ADDRESS_SIZE, default 9, jump field width in words.
REQ-005 SHALL have parameter RESET_PC, default 0, first fetch address; bits [1:0] ignored.
REQ-006 SHALL have one clock, clk, and asynchronous active-low reset, rst_n; no other clock or reset.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 imem_req  output  1  fetch request to instruction memory.
REQ-010 imem_addr  output  PC_SIZE  fetch byte address, bits [1:0] always 0.
REQ-011 imem_ack  input  1  memory response valid; completes the request.
REQ-012 imem_rdata  input  INSTRUCTION_SIZE  fetched word, valid with imem_ack.
REQ-013 instr_valid  output  1  instruction buffer holds a word for decode.
REQ-014 instr_ready  input  1  decode accepts the word.
REQ-015 instruction  output  INSTRUCTION_SIZE  buffered word, feeds the decode stage.
REQ-016 instr_pc  output  PC_SIZE  byte address of buffered word.
REQ-017 redirect_valid  input  1  one-cycle control-flow change request.
REQ-018 redirect_jump  input  1  1 = jump, 0 = taken branch.
REQ-019 redirect_pc  input  PC_SIZE  address of the redirecting instruction.
REQ-020 redirect_offset  input  SMALL_IMMEDIATE_SIZE  signed branch offset in words.
REQ-021 redirect_jaddr  input  JUMP_ADDRESS_SIZE  jump target field in words.

Function
REQ-022 SHALL implement FSM states FETCH, DROP, HOLD; one outstanding memory request maximum.
REQ-023 FETCH: imem_req=1, imem_addr=pc; held stable until imem_ack; on ack, buffer word and pc, pc+=4, go HOLD.
REQ-024 HOLD: instr_valid=1, imem_req=0; instruction/instr_pc stable; on instr_valid&instr_ready, go FETCH next cycle.
REQ-025 Latency: imem_ack in cycle N -> instr_valid=1 in cycle N+1.
REQ-026 Branch target SHALL be redirect_pc + sign-extended {redirect_offset,2'b00}, modulo 2^PC_SIZE.
REQ-027 Jump target SHALL be {redirect_pc[PC_SIZE-1:JUMP_ADDRESS_SIZE+2], redirect_jaddr, 2'b00}.
REQ-028 PC increment SHALL wrap modulo 2^PC_SIZE (0xFFFC -> 0x0000 for default).
REQ-029 Redirect in HOLD: pc<=target, instr_valid=0 next cycle, go FETCH; a simultaneous instr_ready handshake still counts as consumed.
REQ-030 Redirect in FETCH without imem_ack: pc<=target, go DROP; imem_req/imem_addr remain unchanged until ack.
REQ-031 Redirect in FETCH with imem_ack same cycle: response discarded, pc<=target, go FETCH.
REQ-032 DROP: imem_req=1 on old address; on imem_ack discard word, go FETCH; a further redirect overwrites pc, stays DROP.
REQ-033 instr_valid SHALL never be 1 for a word fetched before the latest redirect.
REQ-034 Redirect in FETCH/DROP SHALL not assert instr_valid.

Reset
REQ-035 On rst_n=0: state=FETCH, pc={RESET_PC[PC_SIZE-1:2],2'b00}, instr_valid=0, instruction=0, instr_pc=0, imem_req=0.
REQ-036 imem_req SHALL first assert on the first rising clk after rst_n deasserts; reset mid-request abandons it without waiting for ack.

Structure
REQ-037 Shared package cpu_pkg SHALL hold INSTRUCTION_SIZE, PC_SIZE, SMALL_IMMEDIATE_SIZE, JUMP_ADDRESS_SIZE and the FSM state typedef; decode stage uses the same size constants.
REQ-038 Target computation SHALL be one combinational sub-module, next_pc_calc.

Verification
REQ-039 Reset release, ack 2 cycles after each req, instr_ready=1 -> imem_addr 0x0000,0x0004,0x0008; instr_pc matches.
REQ-040 instr_ready=0 for 5 cycles in HOLD -> instruction/instr_pc stable, imem_req=0 throughout.
REQ-041 Branch redirect_pc=0x0010, offset=0x3FF -> next imem_addr 0x000C; offset=0x004 -> 0x0020.
REQ-042 Jump redirect_pc=0xF804, jaddr=0x1FF -> next imem_addr 0xFFFC; following fetch 0x0000.
REQ-043 Redirect to 0x0040 while req pending, ack 3 cycles later -> word discarded, instr_valid stays 0, then req at 0x0040.
REQ-044 rst_n low mid-FETCH and mid-HOLD -> outputs at reset values asynchronously; restart at RESET_PC.
